// File: rtl/axi_bridge_pkg.sv
// Shared AXI encodings, bridge FSM states and burst legality helper for the
// AXI4-to-memory bridge.
package axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_WRESP = 2'd2,
    ST_RD    = 2'd3
  } bridge_state_e;

  // True when a burst must be answered with SLVERR instead of touching memory.
  function automatic logic burst_illegal(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst, input logic [2:0] size_max);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > size_max) || (burst == 2'b11) ||
           ((burst == AXI_BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts; shared by
// the read and write paths of the bridge.
module axi_burst_addr_gen
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;

  assign step = {{(ADDR_W-1){1'b0}}, 1'b1} << size;
  assign incr = addr + step;
  // WRAP keeps the bits above the burst-sized window and increments inside it.
  assign mask = (({{(ADDR_W-8){1'b0}}, len} + {{(ADDR_W-1){1'b0}}, 1'b1}) << size)
                - {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    case (burst)
      AXI_BURST_FIXED: next_addr = addr;
      AXI_BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
      default:         next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi2mem_bridge_gen2.sv
// AXI4 slave to single-port synchronous memory bridge with fair AW/AR
// arbitration, a two-entry read buffer and SLVERR for illegal bursts.
module axi2mem_bridge_gen2
  import axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 11
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                m_cs,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_byte,
  output logic [DATA_W-1:0]   m_di,
  input  logic [DATA_W-1:0]   m_do,
  input  logic                m_busy
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));

  bridge_state_e     state;
  logic              rd_prio, err, werr, out;
  logic [ID_W-1:0]   id;
  logic [ADDR_W-1:0] addr, next_addr;
  logic [7:0]        len, cnt;
  logic [2:0]        size;
  logic [1:0]        burst;
  logic [8:0]        icnt;
  logic [DATA_W-1:0] fifo [2];
  logic              wptr, rptr;
  logic [1:0]        fcnt;
  logic              in_idle, in_wr, in_rd;
  logic              aw_hs, ar_hs, w_hs, r_hs, pop, rd_cs, rd_acc, capture;

  assign in_idle = (state == ST_IDLE);
  assign in_wr   = (state == ST_WR);
  assign in_rd   = (state == ST_RD);

  // rd_prio starts at 0 so the first tie after reset goes to the write channel.
  assign s_awready = in_idle & s_awvalid & (~s_arvalid | ~rd_prio);
  assign s_arready = in_idle & s_arvalid & (~s_awvalid | rd_prio);
  assign aw_hs     = s_awvalid & s_awready;
  assign ar_hs     = s_arvalid & s_arready;

  assign s_wready = in_wr & (err | ~m_busy);
  assign w_hs     = s_wvalid & s_wready;

  assign s_rvalid = in_rd & (err | (fcnt != 2'd0));
  assign r_hs     = s_rvalid & s_rready;
  assign pop      = r_hs & ~err;
  // A slot freed by this cycle's pop may be reused so one beat/cycle is sustained.
  assign rd_cs    = in_rd & ~err & (icnt != 9'd0) &
                    (({1'b0, out} + fcnt - {1'b0, pop}) < 2'd2);
  assign rd_acc   = rd_cs & ~m_busy;
  assign capture  = out & ~m_busy;

  assign s_rdata = (in_rd & ~err & (fcnt != 2'd0)) ? fifo[rptr] : {DATA_W{1'b0}};
  assign s_rlast = s_rvalid & (cnt == 8'd0);
  assign s_rresp = (s_rvalid & err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_rid   = id;

  assign s_bvalid = (state == ST_WRESP);
  assign s_bresp  = (s_bvalid & (err | werr)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_bid    = id;

  assign m_cs   = (in_wr & s_wvalid & ~m_busy & ~err) | rd_cs;
  assign m_we   = in_wr;
  assign m_addr = addr;
  assign m_byte = in_wr ? s_wstrb : {STRB_W{1'b0}};
  assign m_di   = in_wr ? s_wdata : {DATA_W{1'b0}};

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr      (addr),
    .len       (len),
    .size      (size),
    .burst     (burst),
    .next_addr (next_addr)
  );

  // Bridge FSM: burst latching, beat counting and error tracking.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ST_IDLE;  rd_prio <= 1'b0;  err <= 1'b0;  werr <= 1'b0;  out <= 1'b0;
      id <= {ID_W{1'b0}};  addr <= {ADDR_W{1'b0}};  len <= 8'd0;  cnt <= 8'd0;
      size <= 3'd0;  burst <= 2'd0;  icnt <= 9'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            id <= s_awid;  addr <= s_awaddr;  len <= s_awlen;  cnt <= s_awlen;
            size <= s_awsize;  burst <= s_awburst;  werr <= 1'b0;  rd_prio <= 1'b1;
            err <= burst_illegal(s_awlen, s_awsize, s_awburst, SIZE_MAX);
            state <= ST_WR;
          end else if (ar_hs) begin
            id <= s_arid;  addr <= s_araddr;  len <= s_arlen;  cnt <= s_arlen;
            size <= s_arsize;  burst <= s_arburst;  werr <= 1'b0;  rd_prio <= 1'b0;
            icnt <= {1'b0, s_arlen} + 9'd1;
            err <= burst_illegal(s_arlen, s_arsize, s_arburst, SIZE_MAX);
            state <= ST_RD;
          end
        end
        ST_WR: begin
          if (w_hs) begin
            addr <= next_addr;
            if (s_wlast != (cnt == 8'd0)) werr <= 1'b1;
            if (cnt == 8'd0) state <= ST_WRESP;
            else             cnt   <= cnt - 8'd1;
          end
        end
        ST_WRESP: begin
          if (s_bready) state <= ST_IDLE;
        end
        ST_RD: begin
          if (rd_acc) begin
            addr <= next_addr;
            icnt <= icnt - 9'd1;
          end
          out <= rd_acc | (out & ~capture);
          if (r_hs) begin
            if (cnt == 8'd0) state <= ST_IDLE;
            else             cnt   <= cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Two-entry read buffer fed by memory captures, drained by R handshakes.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      fifo[0] <= {DATA_W{1'b0}};
      fifo[1] <= {DATA_W{1'b0}};
      wptr <= 1'b0;  rptr <= 1'b0;  fcnt <= 2'd0;
    end else begin
      if (capture) begin
        fifo[wptr] <= m_do;
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      fcnt <= fcnt + {1'b0, capture} - {1'b0, pop};
    end
  end

endmodule
